// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake for the iterative RV32M multiply/divide unit.
// The master is the pipeline side; the slave is the unit itself.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, funct3, op_a, op_b, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  valid_i, funct3, op_a, op_b, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider sharing one
// 2*XLEN+1 accumulator, sequenced IDLE -> CALC -> FIX -> DONE.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave bus
);
  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] negate_w(input logic [XLEN-1:0] x);
    return {XLEN{1'b0}} - x;
  endfunction

  function automatic logic [2*XLEN-1:0] negate_d(input logic [2*XLEN-1:0] x);
    return {(2*XLEN){1'b0}} - x;
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic            r_neg;
  // Multiply: {carry, hi, lo}. Divide: {R (XLEN+1 bits), Q (XLEN bits)}.
  logic [2*XLEN:0] r_acc;
  logic [XLEN-1:0] r_opnd;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_is_div;
  logic            w_is_rem;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sign_a;
  logic            w_sign_b;
  logic            w_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_is_div   = bus.funct3[2];
  assign w_is_rem   = bus.funct3[2] & bus.funct3[1];
  assign w_a_signed = (bus.funct3 == F_MULH) | (bus.funct3 == F_MULHSU) |
                      (bus.funct3 == F_DIV)  | (bus.funct3 == F_REM);
  assign w_b_signed = (bus.funct3 == F_MULH) | (bus.funct3 == F_DIV) |
                      (bus.funct3 == F_REM);
  assign w_sign_a   = w_a_signed & bus.op_a[XLEN-1];
  assign w_sign_b   = w_b_signed & bus.op_b[XLEN-1];
  assign w_mag_a    = w_sign_a ? negate_w(bus.op_a) : bus.op_a;
  assign w_mag_b    = w_sign_b ? negate_w(bus.op_b) : bus.op_b;
  // A remainder takes the dividend's sign; products and quotients the XOR.
  assign w_neg      = w_is_rem ? w_sign_a : (w_sign_a ^ w_sign_b);

  assign w_div_zero = w_is_div & (bus.op_b == {XLEN{1'b0}});
  assign w_div_ovf  = w_is_div & ~bus.funct3[0] &
                      (bus.op_a == MOST_NEG) & (bus.op_b == ALL_ONES);
  assign w_fast     = w_div_zero | w_div_ovf;
  assign w_fast_res = w_div_zero ? (w_is_rem ? bus.op_a : ALL_ONES)
                                 : (w_is_rem ? {XLEN{1'b0}} : MOST_NEG);

  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_mul_sum;
  logic [2*XLEN:0] w_mul_next;
  logic [2*XLEN:0] w_div_shift;
  logic [XLEN+1:0] w_trial;
  logic [2*XLEN:0] w_div_next;

  assign w_hi        = r_acc[2*XLEN-1:XLEN];
  assign w_lo        = r_acc[XLEN-1:0];
  assign w_mul_sum   = {r_acc[2*XLEN], w_hi} +
                       (w_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mul_next  = {1'b0, w_mul_sum, w_lo[XLEN-1:1]};
  assign w_div_shift = {r_acc[2*XLEN-1:0], 1'b0};
  assign w_trial     = {1'b0, w_div_shift[2*XLEN:XLEN]} - {2'b00, r_opnd};
  assign w_div_next  = w_trial[XLEN+1] ? w_div_shift
                                       : {w_trial[XLEN:0], w_div_shift[XLEN-1:1], 1'b1};

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_fix_res;

  // Result selection and sign correction applied in FIX.
  always_comb begin
    w_prod = r_neg ? negate_d(r_acc[2*XLEN-1:0]) : r_acc[2*XLEN-1:0];
    case (r_funct3)
      F_MUL:                     w_fix_res = w_lo;
      F_MULH, F_MULHSU, F_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             w_fix_res = r_neg ? negate_w(w_lo) : w_lo;
      F_REM, F_REMU:             w_fix_res = r_neg ? negate_w(w_hi) : w_hi;
      default:                   w_fix_res = w_lo;
    endcase
  end

  // Sequencer: accept, iterate XLEN times, correct, pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_funct3 <= 3'b000;
      r_neg    <= 1'b0;
      r_acc    <= {(2*XLEN+1){1'b0}};
      r_opnd   <= {XLEN{1'b0}};
      r_done   <= 1'b0;
      r_result <= {XLEN{1'b0}};
    end else if (bus.flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.valid_i) begin
            r_funct3 <= bus.funct3;
            r_neg    <= w_neg;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_acc   <= {{(XLEN+1){1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
              r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
              r_cnt   <= CNT_LOAD;
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  logic w_done;

  // A flush arriving in the DONE cycle suppresses the pulse so EX never retires it.
  assign w_done       = r_done & ~bus.flush_i;
  assign bus.done_o   = w_done;
  assign bus.busy_o   = (r_state != S_IDLE);
  assign bus.stall_o  = bus.valid_i & ~w_done & ~bus.flush_i;
  assign bus.result_o = r_result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized bench for muldiv_sequencer against a plain-arithmetic
// RV32M reference model.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cycle;
  int   done_cnt;
  int   last_done_cycle;
  logic [31:0] last_res;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (bus.done_o === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'b000: begin r = ua * ub; return r[31:0]; end
      3'b001: begin r = sa * sb; return r[63:32]; end
      3'b010: begin r = sa * ub; return r[63:32]; end
      3'b011: begin r = ua * ub; return r[63:32]; end
      3'b100: begin if (b == 32'd0) return 32'hFFFF_FFFF; r = sa / sb; return r[31:0]; end
      3'b101: begin if (b == 32'd0) return 32'hFFFF_FFFF; r = ua / ub; return r[31:0]; end
      3'b110: begin if (b == 32'd0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 32'd0) return a; r = ua % ub; return r[31:0]; end
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'd0) ||
                     (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'(int'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  // Presents one instruction in the current (IDLE) cycle, holds valid until done_o,
  // then advances EX one edge and drops valid.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp_res;
    int exp_lat;
    int lat;
    bit seen;
    bit stall_ok;
    exp_res = ref_result(f3, a, b);
    exp_lat = ref_fast(f3, a, b) ? 1 : XLEN + 2;
    bus.funct3  = f3;
    bus.op_a    = a;
    bus.op_b    = b;
    bus.valid_i = 1'b1;
    lat = 0;
    seen = 1'b0;
    #1;
    stall_ok = (bus.stall_o === 1'b1);
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.op_a = $urandom;
        bus.op_b = $urandom;
      end
      #1;
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        last_done_cycle = cycle;
      end else if (bus.stall_o !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, bus.result_o, exp_res);
    check({tag, "_stall_hold"}, {31'd0, stall_ok}, 32'd1);
    check({tag, "_stall_done"}, {31'd0, bus.stall_o}, 32'd0);
    last_res = exp_res;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    #1;
    check({tag, "_done_pulse"}, {31'd0, bus.done_o}, 32'd0);
    check({tag, "_idle_after"}, {31'd0, bus.busy_o}, 32'd0);
  endtask

  initial begin
    int d0;
    int c1;
    checks = 0;
    failures = 0;
    cycle = 0;
    done_cnt = 0;
    last_done_cycle = 0;
    last_res = 32'd0;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.funct3  = 3'b000;
    bus.op_a    = 32'd0;
    bus.op_b    = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset_done", {31'd0, bus.done_o}, 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    check("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_neg");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, "mulhsu");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_neg");
    run_op(3'b101, 32'd100, 32'd7, "divu");
    run_op(3'b111, 32'd100, 32'd7, "remu");
    run_op(3'b101, 32'd5, 32'd0, "fast_divu0");
    run_op(3'b110, 32'd5, 32'd0, "fast_rem0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "fast_div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "fast_rem_ovf");

    // Flush 10 cycles into a DIV.
    bus.funct3  = 3'b100;
    bus.op_a    = 32'd1000;
    bus.op_b    = 32'd3;
    bus.valid_i = 1'b1;
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    #1;
    check("flush_stall", {31'd0, bus.stall_o}, 32'd0);
    check("flush_done", {31'd0, bus.done_o}, 32'd0);
    @(posedge clk); #1;
    check("flush_idle", {31'd0, bus.busy_o}, 32'd0);
    // Flush wins over an accept attempted in IDLE.
    @(posedge clk); #1;
    check("flush_no_accept", {31'd0, bus.busy_o}, 32'd0);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_done", 32'(done_cnt - d0), 32'd0);
    check("flush_result_kept", bus.result_o, last_res);
    run_op(3'b000, 32'd3, 32'd4, "post_flush_mul");

    // Reset in the middle of a MUL.
    bus.funct3  = 3'b000;
    bus.op_a    = 32'd9;
    bus.op_b    = 32'd9;
    bus.valid_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mid_mul_busy", {31'd0, bus.busy_o}, 32'd1);
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("midrst_done", {31'd0, bus.done_o}, 32'd0);
    check("midrst_result", bus.result_o, 32'd0);
    check("midrst_stall", {31'd0, bus.stall_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back MUL then DIV with valid held across the boundary.
    d0 = done_cnt;
    run_op(3'b000, 32'd1234, 32'd5678, "b2b_mul");
    c1 = last_done_cycle;
    run_op(3'b100, 32'hFFFF_F000, 32'd7, "b2b_div");
    check("b2b_spacing", 32'(last_done_cycle - c1), 32'(XLEN + 3));
    repeat (5) @(posedge clk);
    #1;
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op(f3, a, b, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
